// File: rtl/rs_queue.sv
// Reservation station with age-matrix oldest-first select and CDB wakeup.
// Optional RS_WAKEUP_BYPASS_EN lets a same-cycle CDB match make an entry issue-eligible.
module rs_queue #(
    parameter int ENTRIES    = 8,
    parameter int DISPATCH_W = 2,
    parameter int ISSUE_W    = 2,
    parameter int CDB_W      = 2,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32,
    parameter int ROB_W      = 5,
    parameter int PAY_W      = 48,
    localparam int CNT_W     = $clog2(ENTRIES + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [DISPATCH_W-1:0]               disp_valid,
    output logic                                disp_ready,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]    disp_src1_tag,
    input  logic [DISPATCH_W-1:0][TAG_W-1:0]    disp_src2_tag,
    input  logic [DISPATCH_W-1:0]               disp_src1_rdy,
    input  logic [DISPATCH_W-1:0]               disp_src2_rdy,
    input  logic [DISPATCH_W-1:0][DATA_W-1:0]   disp_src1_data,
    input  logic [DISPATCH_W-1:0][DATA_W-1:0]   disp_src2_data,
    input  logic [DISPATCH_W-1:0][ROB_W-1:0]    disp_rob,
    input  logic [DISPATCH_W-1:0][PAY_W-1:0]    disp_pay,
    input  logic [CDB_W-1:0]                    cdb_valid,
    input  logic [CDB_W-1:0][TAG_W-1:0]         cdb_tag,
    input  logic [CDB_W-1:0][DATA_W-1:0]        cdb_data,
    input  logic [ISSUE_W-1:0]                  fu_ready,
    output logic [ISSUE_W-1:0]                  iss_valid,
    output logic [ISSUE_W-1:0][DATA_W-1:0]      iss_src1,
    output logic [ISSUE_W-1:0][DATA_W-1:0]      iss_src2,
    output logic [ISSUE_W-1:0][ROB_W-1:0]       iss_rob,
    output logic [ISSUE_W-1:0][PAY_W-1:0]       iss_pay,
    output logic [CNT_W-1:0]                    count
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int RK_W  = $clog2(ENTRIES + ISSUE_W + 1);

    logic [ENTRIES-1:0]                 valid_q;
    logic [ENTRIES-1:0]                 s1_rdy_q, s2_rdy_q;
    logic [ENTRIES-1:0][TAG_W-1:0]      s1_tag_q, s2_tag_q;
    logic [ENTRIES-1:0][DATA_W-1:0]     s1_data_q, s2_data_q;
    logic [ENTRIES-1:0][ROB_W-1:0]      rob_q;
    logic [ENTRIES-1:0][PAY_W-1:0]      pay_q;
    // older_q[i][j] set: entry i is older than entry j
    logic [ENTRIES-1:0][ENTRIES-1:0]    older_q, older_d;

    logic [ENTRIES-1:0]                 s1_hit, s2_hit;
    logic [ENTRIES-1:0][DATA_W-1:0]     s1_cdb, s2_cdb;
    logic [DISPATCH_W-1:0]              d1_hit, d2_hit;
    logic [DISPATCH_W-1:0][DATA_W-1:0]  d1_cdb, d2_cdb;
    logic [ENTRIES-1:0]                 cand;
    logic [ENTRIES-1:0][DATA_W-1:0]     op1, op2;
    logic [ENTRIES-1:0][RK_W-1:0]       rank;
    logic [ISSUE_W-1:0][RK_W-1:0]       ord;
    logic [ISSUE_W-1:0]                 lane_hit;
    logic [ISSUE_W-1:0][IDX_W-1:0]      lane_idx;
    logic [ENTRIES-1:0]                 issue_mask;
    logic [CNT_W-1:0]                   n_iss, n_disp;
    logic [ENTRIES-1:0]                 taken, alloc;
    logic [DISPATCH_W-1:0][IDX_W-1:0]   d_idx;
    logic                               accept;

    assign disp_ready = (CNT_W'(ENTRIES) - count) >= CNT_W'(DISPATCH_W);
    assign accept     = disp_ready & ~flush;

    // Descending lane scan so the lowest matching CDB lane wins
    always_comb begin
        s1_hit = '0;
        s2_hit = '0;
        s1_cdb = '0;
        s2_cdb = '0;
        d1_hit = '0;
        d2_hit = '0;
        d1_cdb = '0;
        d2_cdb = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int c = CDB_W - 1; c >= 0; c--) begin
                if (cdb_valid[c] && cdb_tag[c] == s1_tag_q[i]) begin
                    s1_hit[i] = valid_q[i] & ~s1_rdy_q[i];
                    s1_cdb[i] = cdb_data[c];
                end
                if (cdb_valid[c] && cdb_tag[c] == s2_tag_q[i]) begin
                    s2_hit[i] = valid_q[i] & ~s2_rdy_q[i];
                    s2_cdb[i] = cdb_data[c];
                end
            end
        end
        for (int l = 0; l < DISPATCH_W; l++) begin
            for (int c = CDB_W - 1; c >= 0; c--) begin
                if (cdb_valid[c] && cdb_tag[c] == disp_src1_tag[l]) begin
                    d1_hit[l] = 1'b1;
                    d1_cdb[l] = cdb_data[c];
                end
                if (cdb_valid[c] && cdb_tag[c] == disp_src2_tag[l]) begin
                    d2_hit[l] = 1'b1;
                    d2_cdb[l] = cdb_data[c];
                end
            end
        end
    end

`ifdef RS_WAKEUP_BYPASS_EN
    assign cand = valid_q & (s1_rdy_q | s1_hit) & (s2_rdy_q | s2_hit);
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            op1[i] = s1_rdy_q[i] ? s1_data_q[i] : s1_cdb[i];
            op2[i] = s2_rdy_q[i] ? s2_data_q[i] : s2_cdb[i];
        end
    end
`else
    assign cand = valid_q & s1_rdy_q & s2_rdy_q;
    assign op1  = s1_data_q;
    assign op2  = s2_data_q;
`endif

    // Rank = number of older candidates; lane ordinal = ready lanes below it
    always_comb begin
        ord        = '0;
        rank       = '0;
        lane_hit   = '0;
        lane_idx   = '0;
        issue_mask = '0;
        n_iss      = '0;
        for (int k = 1; k < ISSUE_W; k++)
            ord[k] = ord[k-1] + RK_W'(fu_ready[k-1]);
        for (int i = 0; i < ENTRIES; i++)
            for (int j = 0; j < ENTRIES; j++)
                if (cand[j] && older_q[j][i])
                    rank[i] = rank[i] + RK_W'(1);
        for (int k = 0; k < ISSUE_W; k++)
            for (int i = 0; i < ENTRIES; i++)
                if (fu_ready[k] && cand[i] && rank[i] == ord[k]) begin
                    lane_hit[k] = 1'b1;
                    lane_idx[k] = IDX_W'(i);
                end
        for (int k = 0; k < ISSUE_W; k++)
            if (lane_hit[k]) begin
                issue_mask[lane_idx[k]] = 1'b1;
                n_iss = n_iss + CNT_W'(1);
            end
    end

    always_comb begin
        taken  = '0;
        d_idx  = '0;
        n_disp = '0;
        for (int l = 0; l < DISPATCH_W; l++) begin
            if (disp_valid[l]) begin
                for (int i = ENTRIES - 1; i >= 0; i--)
                    if (!valid_q[i] && !taken[i])
                        d_idx[l] = IDX_W'(i);
                taken[d_idx[l]] = 1'b1;
                n_disp = n_disp + CNT_W'(1);
            end
        end
        alloc = accept ? taken : '0;
        if (!accept)
            n_disp = '0;
    end

    // New entries are younger than residents; lower lanes older than higher
    always_comb begin
        older_d = older_q;
        for (int l = 0; l < DISPATCH_W; l++) begin
            if (accept && disp_valid[l]) begin
                for (int j = 0; j < ENTRIES; j++)
                    older_d[d_idx[l]][j] = 1'b0;
                for (int r = 0; r < ENTRIES; r++)
                    older_d[r][d_idx[l]] = valid_q[r];
            end
        end
        for (int l = 0; l < DISPATCH_W; l++)
            for (int m = l + 1; m < DISPATCH_W; m++)
                if (accept && disp_valid[l] && disp_valid[m])
                    older_d[d_idx[l]][d_idx[m]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            older_q   <= '0;
            count     <= '0;
            iss_valid <= '0;
            iss_src1  <= '0;
            iss_src2  <= '0;
            iss_rob   <= '0;
            iss_pay   <= '0;
        end else if (flush) begin
            valid_q   <= '0;
            count     <= '0;
            iss_valid <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (s1_hit[i]) begin
                    s1_rdy_q[i]  <= 1'b1;
                    s1_data_q[i] <= s1_cdb[i];
                end
                if (s2_hit[i]) begin
                    s2_rdy_q[i]  <= 1'b1;
                    s2_data_q[i] <= s2_cdb[i];
                end
            end
            for (int l = 0; l < DISPATCH_W; l++) begin
                if (accept && disp_valid[l]) begin
                    s1_tag_q[d_idx[l]]  <= disp_src1_tag[l];
                    s2_tag_q[d_idx[l]]  <= disp_src2_tag[l];
                    s1_rdy_q[d_idx[l]]  <= disp_src1_rdy[l] | d1_hit[l];
                    s2_rdy_q[d_idx[l]]  <= disp_src2_rdy[l] | d2_hit[l];
                    s1_data_q[d_idx[l]] <= disp_src1_rdy[l] ?
                                           disp_src1_data[l] : d1_cdb[l];
                    s2_data_q[d_idx[l]] <= disp_src2_rdy[l] ?
                                           disp_src2_data[l] : d2_cdb[l];
                    rob_q[d_idx[l]]     <= disp_rob[l];
                    pay_q[d_idx[l]]     <= disp_pay[l];
                end
            end
            for (int k = 0; k < ISSUE_W; k++) begin
                iss_valid[k] <= lane_hit[k];
                if (lane_hit[k]) begin
                    iss_src1[k] <= op1[lane_idx[k]];
                    iss_src2[k] <= op2[lane_idx[k]];
                    iss_rob[k]  <= rob_q[lane_idx[k]];
                    iss_pay[k]  <= pay_q[lane_idx[k]];
                end
            end
            valid_q <= (valid_q & ~issue_mask) | alloc;
            older_q <= older_d;
            count   <= count + n_disp - n_iss;
        end
    end

endmodule

// File: tb/tb_rs_queue.sv
// Directed self-checking bench for rs_queue (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_rs_queue;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       disp_valid;
    logic             disp_ready;
    logic [1:0][5:0]  disp_src1_tag, disp_src2_tag;
    logic [1:0]       disp_src1_rdy, disp_src2_rdy;
    logic [1:0][31:0] disp_src1_data, disp_src2_data;
    logic [1:0][4:0]  disp_rob;
    logic [1:0][47:0] disp_pay;
    logic [1:0]       cdb_valid;
    logic [1:0][5:0]  cdb_tag;
    logic [1:0][31:0] cdb_data;
    logic [1:0]       fu_ready;
    logic [1:0]       iss_valid;
    logic [1:0][31:0] iss_src1, iss_src2;
    logic [1:0][4:0]  iss_rob;
    logic [1:0][47:0] iss_pay;
    logic [3:0]       count;

    int n_chk = 0;
    int n_pass = 0;
    int lat;

`ifdef RS_WAKEUP_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    rs_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_data(disp_src1_data), .disp_src2_data(disp_src2_data),
        .disp_rob(disp_rob), .disp_pay(disp_pay),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_ready(fu_ready), .iss_valid(iss_valid),
        .iss_src1(iss_src1), .iss_src2(iss_src2),
        .iss_rob(iss_rob), .iss_pay(iss_pay), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        disp_valid     = '0;
        disp_src1_tag  = '0;
        disp_src2_tag  = '0;
        disp_src1_rdy  = '0;
        disp_src2_rdy  = '0;
        disp_src1_data = '0;
        disp_src2_data = '0;
        disp_rob       = '0;
        disp_pay       = '0;
        cdb_valid      = '0;
        cdb_tag        = '0;
        cdb_data       = '0;
    endtask

    function automatic logic [47:0] pay_of(input logic [4:0] rob);
        return {8'hA5, 35'd0, rob};
    endfunction

    task automatic put(input int l, input logic r1, input logic [5:0] t1,
                       input logic [31:0] d1, input logic r2,
                       input logic [5:0] t2, input logic [31:0] d2,
                       input logic [4:0] rob);
        disp_valid[l]     = 1'b1;
        disp_src1_rdy[l]  = r1;
        disp_src1_tag[l]  = t1;
        disp_src1_data[l] = d1;
        disp_src2_rdy[l]  = r2;
        disp_src2_tag[l]  = t2;
        disp_src2_data[l] = d2;
        disp_rob[l]       = rob;
        disp_pay[l]       = pay_of(rob);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        fu_ready = '0;
        clr();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_iss_valid", iss_valid, 0);
        check("rst_disp_ready", disp_ready, 1);
        check("rst_iss_rob", iss_rob, 0);

        // two ready instructions, issued two cycles after dispatch
        put(0, 1, 0, 32'h1111_0001, 1, 0, 32'h2222_0001, 5'd3);
        put(1, 1, 0, 32'h1111_0002, 1, 0, 32'h2222_0002, 5'd4);
        fu_ready = 2'b11;
        step();
        clr();
        check("s1_count_after_disp", count, 2);
        check("s1_iss_early", iss_valid, 0);
        step();
        check("s1_iss_valid", iss_valid, 2'b11);
        check("s1_rob0", iss_rob[0], 3);
        check("s1_rob1", iss_rob[1], 4);
        check("s1_src1_0", iss_src1[0], 32'h1111_0001);
        check("s1_src2_1", iss_src2[1], 32'h2222_0002);
        check("s1_pay0", iss_pay[0], pay_of(5'd3));
        check("s1_count", count, 0);

        // fill with waiting src1 tag 9, then a single broadcast wakes all
        fu_ready = 2'b00;
        for (int c = 0; c < 4; c++) begin
            put(0, 0, 6'd9, 0, 1, 0, 32'h22, 5'(2 * c));
            put(1, 0, 6'd9, 0, 1, 0, 32'h22, 5'(2 * c + 1));
            step();
            clr();
        end
        check("s2_full_count", count, 8);
        check("s2_full_ready", disp_ready, 0);
        check("s2_no_issue", iss_valid, 0);
        cdb_valid[0] = 1'b1;
        cdb_tag[0] = 6'd9;
        cdb_data[0] = 32'h55;
        fu_ready = 2'b11;
        step();
        clr();
        lat = 1;
        while (iss_valid == 2'b00 && lat < 5) begin
            step();
            lat++;
        end
        check("s2_wake_latency", lat, EXP_LAT);
        for (int p = 0; p < 4; p++) begin
            check("s2_drain_valid", iss_valid, 2'b11);
            check("s2_drain_rob0", iss_rob[0], 2 * p);
            check("s2_drain_rob1", iss_rob[1], 2 * p + 1);
            check("s2_drain_src1", iss_src1[1], 32'h55);
            check("s2_drain_count", count, 6 - 2 * p);
            if (p < 3) step();
        end
        step();
        check("s2_empty_count", count, 0);
        check("s2_empty_iss", iss_valid, 0);

        // count = 7: not ready, even while an issue frees an entry
        fu_ready = 2'b00;
        for (int c = 0; c < 3; c++) begin
            put(0, 0, 6'd20, 0, 1, 0, 32'h33, 5'(10 + 2 * c));
            put(1, 0, 6'd20, 0, 1, 0, 32'h33, 5'(11 + 2 * c));
            step();
            clr();
        end
        put(1, 0, 6'd20, 0, 1, 0, 32'h33, 5'd16);
        step();
        clr();
        check("s3_count7", count, 7);
        check("s3_ready_low", disp_ready, 0);
        cdb_valid = 2'b11;
        cdb_tag[0] = 6'd21;
        cdb_data[0] = 32'h99;
        cdb_tag[1] = 6'd20;
        cdb_data[1] = 32'h77;
        step();
        clr();
        fu_ready = 2'b01;
        put(0, 1, 0, 1, 1, 0, 2, 5'd30);
        put(1, 1, 0, 1, 1, 0, 2, 5'd31);
        check("s3_ready_low_issue", disp_ready, 0);
        step();
        clr();
        fu_ready = 2'b00;
        check("s3_one_issue", iss_valid, 2'b01);
        check("s3_rob", iss_rob[0], 10);
        check("s3_src1_lane1cdb", iss_src1[0], 32'h77);
        check("s3_count6", count, 6);
        check("s3_ready_high", disp_ready, 1);
        fu_ready = 2'b11;
        step();
        check("s3_next_rob0", iss_rob[0], 11);
        check("s3_next_rob1", iss_rob[1], 12);
        step();
        step();
        check("s3_drained", count, 0);

        // dispatch-cycle wakeup of src2
        put(0, 1, 0, 32'h11, 0, 6'd5, 0, 5'd7);
        cdb_valid[0] = 1'b1;
        cdb_tag[0] = 6'd5;
        cdb_data[0] = 32'hA1;
        step();
        clr();
        check("s4_count", count, 1);
        step();
        check("s4_iss_valid", iss_valid, 2'b01);
        check("s4_src2", iss_src2[0], 32'hA1);
        check("s4_rob", iss_rob[0], 7);
        check("s4_count0", count, 0);

        // only lane 1 ready
        fu_ready = 2'b10;
        put(0, 1, 0, 32'h5, 1, 0, 32'h6, 5'd9);
        step();
        clr();
        step();
        check("s5_iss_valid", iss_valid, 2'b10);
        check("s5_rob1", iss_rob[1], 9);
        check("s5_count", count, 0);

        // flush with 5 resident entries and a pending dispatch
        fu_ready = 2'b00;
        for (int c = 0; c < 3; c++) begin
            put(0, 0, 6'd30, 0, 1, 0, 0, 5'(2 * c));
            if (c < 2) put(1, 0, 6'd30, 0, 1, 0, 0, 5'(2 * c + 1));
            step();
            clr();
        end
        check("s6_count5", count, 5);
        flush = 1'b1;
        fu_ready = 2'b11;
        put(0, 1, 0, 1, 1, 0, 2, 5'd20);
        put(1, 1, 0, 1, 1, 0, 2, 5'd21);
        check("s6_ready_preflush", disp_ready, 1);
        step();
        flush = 1'b0;
        clr();
        check("s6_count0", count, 0);
        check("s6_iss0", iss_valid, 0);
        cdb_valid[0] = 1'b1;
        cdb_tag[0] = 6'd30;
        step();
        clr();
        step();
        check("s6_absent_iss", iss_valid, 0);
        check("s6_absent_count", count, 0);

        // reset mid-operation clears issue data registers
        put(0, 1, 0, 32'hCAFE, 1, 0, 32'hBEEF, 5'd13);
        step();
        clr();
        step();
        check("s7_pre_rob", iss_rob[0], 13);
        check("s7_pre_valid", iss_valid, 2'b01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s7_iss_valid", iss_valid, 0);
        check("s7_iss_rob", iss_rob, 0);
        check("s7_iss_pay", iss_pay, 0);
        check("s7_iss_src1", iss_src1, 0);
        check("s7_count", count, 0);
        check("s7_ready", disp_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rs_queue.md
# rs_queue

Parametrised reservation station for the out-of-order core: it sits between decode/rename and the functional-unit pools. It accepts up to DISPATCH_W renamed instructions per cycle and wakes waiting operands by tag match on CDB_W result-bus broadcasts. Each cycle it issues up to ISSUE_W ready instructions, oldest first, through registered issue ports. One instance serves one FU class (mul, add or alu); depth, widths and lane counts are parameters.

## Interface
- ENTRIES, 8: station depth; must be ≥ DISPATCH_W.
- DISPATCH_W, 2: dispatch lanes.
- ISSUE_W, 2: issue lanes, one per FU.
- CDB_W, 2: result broadcast lanes.
- TAG_W, 6: physical register tag width.
- DATA_W, 32: operand width.
- ROB_W, 5: ROB index width.
- PAY_W, 48: opaque payload (op, func, imm, pc), carried unmodified.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  squash all entries.
- disp_valid  in  DISPATCH_W  lane valid.
- disp_ready  out  1  all valid lanes accepted this cycle.
- disp_src1_tag, disp_src2_tag  in  DISPATCH_W×TAG_W  source tags.
- disp_src1_rdy, disp_src2_rdy  in  DISPATCH_W  operand already valid.
- disp_src1_data, disp_src2_data  in  DISPATCH_W×DATA_W  operand values, used when rdy=1.
- disp_rob  in  DISPATCH_W×ROB_W  ROB index.
- disp_pay  in  DISPATCH_W×PAY_W  payload.
- cdb_valid  in  CDB_W  broadcast valid.
- cdb_tag  in  CDB_W×TAG_W  produced tag.
- cdb_data  in  CDB_W×DATA_W  produced value.
- fu_ready  in  ISSUE_W  FU k accepts an instruction next cycle.
- iss_valid  out  ISSUE_W  registered issue valid.
- iss_src1, iss_src2  out  ISSUE_W×DATA_W  operands.
- iss_rob  out  ISSUE_W×ROB_W  ROB index.
- iss_pay  out  ISSUE_W×PAY_W  payload.
- count  out  clog2(ENTRIES+1)  occupied entries.

## Operation
- Per entry: valid, src1/src2 {rdy, tag, data}, rob, pay, and an ENTRIES×ENTRIES age matrix row (older-than bits).
- disp_ready = (ENTRIES − count) ≥ DISPATCH_W, computed from registered state only; entries freed by this cycle's issue do not count.
- Dispatch is all-or-nothing. When disp_ready=1, each valid lane takes the lowest-index free entry in lane order. Lanes with disp_valid=0 consume nothing and may be non-contiguous. A lower lane is older than a higher lane; every new entry is younger than all resident entries.
- Wakeup: each cycle every valid, non-ready source compares its tag against all cdb lanes; on a match it latches cdb_data and sets rdy. A dispatching source with rdy=0 whose tag matches a same-cycle broadcast is written as ready with the CDB data, so no wakeup is lost. Two CDB lanes carrying the same tag is illegal; the lowest lane wins.
- Select: an entry is a candidate when valid and both sources are rdy in registered state. Candidates are ranked by age. The j-th oldest goes to the j-th issue lane with fu_ready=1, scanning lanes upward. A selected entry is freed at the clock edge and its fields are registered onto that lane.
- iss_valid[k] is low whenever fu_ready[k] was low or no candidate remained.
- count is updated each cycle: +accepted dispatches − issues.
- flush has priority over dispatch, wakeup and issue. At the next edge it clears every valid bit, iss_valid and count, and ignores dispatch that cycle. disp_ready still reflects pre-flush state.

## Timing
- Reset values: all entry valid bits 0, age matrix 0, count 0, iss_valid 0, iss_src1/iss_src2/iss_rob/iss_pay 0. disp_ready is 1 after reset.
- rst mid-operation behaves like flush and also zeroes the iss_* data registers.
- A ready-at-dispatch instruction written at edge t is selectable in cycle t+1 and seen on iss_* in cycle t+2.
- A CDB wakeup in cycle t makes the entry selectable in cycle t+1 (base build).
- Full: with count=ENTRIES−DISPATCH_W+1, disp_ready=0 even if an issue frees an entry that cycle.
- Simultaneous dispatch, wakeup and issue of different entries in one cycle are independent.

## Configuration
- RS_WAKEUP_BYPASS_EN defined: a resident entry whose last missing source matches a CDB broadcast in cycle t is a select candidate in cycle t. Its CDB value is muxed into iss_src* at edge t, which saves one cycle. Dispatch-cycle matches are excluded from bypass.
- Undefined: the wakeup-to-issue path is strictly registered; candidacy starts at t+1.

## Test plan
- Reset, then dispatch 2 ready instructions with rob 3 and rob 4, fu_ready=2'b11 → cycle t+2: iss_valid=2'b11, lane0 rob 3, lane1 rob 4, count returns to 0.
- Fill 8 entries with waiting src1 tag 9; cdb tag 9, data 0x55 → all become ready; the oldest two issue per cycle in age order with iss_src1=0x55; drains in 4 issue cycles.
- count=7, DISPATCH_W=2 → disp_ready=0; issue one → disp_ready=1 the following cycle only.
- Dispatch with src2 tag 5 rdy=0 while cdb tag 5, data 0xA1 in the same cycle → entry ready; issued with iss_src2=0xA1, no hang.
- fu_ready=2'b10 with one candidate → iss_valid=2'b10, lane 1 carries it.
- Flush while 5 entries are valid and a dispatch is pending → next cycle count=0, iss_valid=0, the dispatched instruction is absent. With RS_WAKEUP_BYPASS_EN, the wakeup-to-iss_valid latency measures 1 cycle instead of 2.
